// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetches byte instructions from program memory,
// drives an external ALU and maintains a 4-entry register file, PC and Z flag.
module control_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic       halted,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_OPND   = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          r_state;
  logic [7:0]      r_pc;
  logic [7:0]      r_ir;
  logic [3:0][7:0] r_regs;
  logic            r_z;
  logic            r_req;
  logic            r_halted;

  // r_req / r_halted are updated together with the state so they are high exactly
  // in FETCH/OPND and HALT respectively.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= 8'h00;
      r_ir     <= 8'h00;
      r_regs   <= '0;
      r_z      <= 1'b0;
      r_req    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_data;
            r_pc    <= r_pc + 8'd1;
            r_state <= S_DECODE;
            r_req   <= 1'b0;
          end
        end
        S_DECODE: begin
          if (!r_ir[7]) begin
            r_state <= S_EXEC;
          end else if (r_ir[6:5] == 2'b11) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_OPND;
            r_req   <= 1'b1;
          end
        end
        S_OPND: begin
          // The request stays high: the next instruction fetch follows directly.
          if (imem_ack) begin
            r_state <= S_FETCH;
            case (r_ir[6:5])
              2'b00: begin
                r_regs[r_ir[1:0]] <= imem_data;
                r_pc              <= r_pc + 8'd1;
              end
              2'b01:   r_pc <= r_z ? imem_data : r_pc + 8'd1;
              default: r_pc <= imem_data;
            endcase
          end
        end
        S_EXEC: begin
          r_regs[r_ir[3:2]] <= alu_result;
          r_z               <= alu_zero;
          r_state           <= S_FETCH;
          r_req             <= 1'b1;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state  <= S_IDLE;
          r_req    <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // Operands are read from the current register contents, so rd==rs sees the old value.
  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign alu_op    = r_ir[6:4];
  assign alu_a     = r_regs[r_ir[3:2]];
  assign alu_b     = r_regs[r_ir[1:0]];
  assign halted    = r_halted;
  assign dbg_data  = r_regs[dbg_sel];

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: memory responder with wait states, external ALU,
// instruction-level reference model feeding an expected-fetch scoreboard.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       halted;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  mem [256];
  int          wait_arr [1024];
  logic [15:0] exp_q [$];   // {expected gap in cycles (0 = unchecked), expected address}
  logic [7:0]  m_r [4];
  logic [7:0]  m_pc;

  control_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .halted     (halted),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- external ALU ----------------
  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return a + 8'd1;
      default: return a - 8'd1;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == 8'h00);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder (driver) ----------------
  initial begin : responder
    int nb;
    int left;
    bit armed;
    nb = 0;
    left = 0;
    armed = 0;
    imem_ack = 1'b0;
    imem_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n || !imem_req) begin
        if (!rst_n) nb = 0;
        armed = 0;
        imem_ack  = 1'($urandom_range(0, 1));
        imem_data = 8'($urandom);
      end else begin
        if (!armed) begin
          left  = wait_arr[nb % 1024];
          armed = 1;
        end
        if (left > 0) begin
          left--;
          imem_ack  = 1'b0;
          imem_data = 8'($urandom);
        end else begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr];
          armed     = 0;
          nb++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int cyc;
    int last_c;
    bit prev_wait;
    logic [7:0] prev_addr;
    logic [15:0] e;
    cyc = 0;
    last_c = 0;
    prev_wait = 0;
    prev_addr = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        prev_wait = 0;
      end else begin
        if (prev_wait) begin
          check("req_hold", imem_req, 1'b1);
          check("addr_stable", imem_addr, prev_addr);
        end
        prev_wait = imem_req && !imem_ack;
        prev_addr = imem_addr;
        if (imem_req && imem_ack) begin
          if (exp_q.size() == 0) begin
            check("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("fetch_addr", imem_addr, e[7:0]);
            if (e[15:8] != 8'd0) check("fetch_gap", cyc - last_c, e[15:8]);
          end
          last_c = cyc;
        end
      end
    end
  end

  // ---------------- reference model (instruction-level interpreter) ----------------
  task automatic model_run();
    logic [7:0] pc;
    logic [7:0] op;
    logic [7:0] d;
    logic [7:0] res;
    logic [7:0] g;
    logic       z;
    int         k;
    int         gap_next;
    bit         first;
    pc = 8'h00;
    z = 1'b0;
    k = 0;
    gap_next = 0;
    first = 1;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    exp_q.delete();
    for (int s = 0; s < 300; s++) begin
      op = mem[pc];
      g = first ? 8'd0 : 8'(gap_next + wait_arr[k % 1024]);
      exp_q.push_back({g, pc});
      first = 0;
      k++;
      pc = pc + 8'd1;
      if (!op[7]) begin
        res = alu_ref(op[6:4], m_r[op[3:2]], m_r[op[1:0]]);
        m_r[op[3:2]] = res;
        z = (res == 8'h00);
        gap_next = 3;
      end else if (op[6:5] == 2'b11) begin
        break;
      end else begin
        exp_q.push_back({8'(2 + wait_arr[k % 1024]), pc});
        d = mem[pc];
        k++;
        pc = pc + 8'd1;
        case (op[6:5])
          2'b00:   m_r[op[1:0]] = d;
          2'b01:   if (z) pc = d;
          default: pc = d;
        endcase
        gap_next = 1;
      end
    end
    m_pc = pc;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic fill_random_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  task automatic set_waits(input int lo, input int hi);
    for (int i = 0; i < 1024; i++) wait_arr[i] = $urandom_range(hi, lo);
  endtask

  task automatic begin_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_rst_req"}, imem_req, 1'b0);
    check({tag, "_rst_halted"}, halted, 1'b0);
    check({tag, "_rst_pc"}, imem_addr, 8'h00);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check({tag, "_rst_reg"}, dbg_data, 8'h00);
    end
  endtask

  task automatic run_prog(input string tag, input int max_cyc);
    int c;
    model_run();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      #3;
      if (halted && exp_q.size() == 0) break;
    end
    check({tag, "_finished_in_budget"}, (c < max_cyc), 1'b1);
    repeat (8) @(negedge clk);
    #3;
    check({tag, "_halted"}, halted, 1'b1);
    check({tag, "_req_low"}, imem_req, 1'b0);
    check({tag, "_pc"}, imem_addr, m_pc);
    check({tag, "_pending"}, exp_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check({tag, "_reg"}, dbg_data, m_r[i]);
    end
  endtask

  task automatic load_sub_prog(input logic [7:0] r1_val);
    fill_random_mem();
    mem[0] = 8'h80; mem[1] = 8'h05;
    mem[2] = 8'h81; mem[3] = r1_val;
    mem[4] = 8'h21;
    mem[5] = 8'hA0; mem[6] = 8'h10;
    mem[7] = 8'hE0;
    mem[8'h10] = 8'hE0;
  endtask

  task automatic load_not_prog();
    fill_random_mem();
    mem[0] = 8'h80; mem[1] = 8'hAA;
    mem[2] = 8'h00;
    mem[3] = 8'hE0;
  endtask

  task automatic load_random_prog();
    int         n;
    int         kind [32];
    logic [7:0] adr [33];
    logic [7:0] p;
    fill_random_mem();
    n = $urandom_range(20, 6);
    p = 8'h00;
    for (int i = 0; i < n; i++) begin
      kind[i] = $urandom_range(7, 0);
      adr[i] = p;
      p = p + ((kind[i] < 4) ? 8'd1 : 8'd2);
    end
    adr[n] = p;
    for (int i = 0; i < n; i++) begin
      case (kind[i])
        0, 1, 2, 3: mem[adr[i]] = {1'b0, 3'($urandom), 4'($urandom)};
        4, 5:       mem[adr[i]] = {3'b100, 3'($urandom), 2'($urandom)};
        6: begin
          mem[adr[i]] = {3'b101, 5'($urandom)};
          mem[8'(adr[i] + 8'd1)] = adr[$urandom_range(n, i + 1)];
        end
        default: begin
          mem[adr[i]] = {3'b110, 5'($urandom)};
          mem[8'(adr[i] + 8'd1)] = adr[$urandom_range(n, i + 1)];
        end
      endcase
    end
    mem[adr[n]] = {3'b111, 5'($urandom)};
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    dbg_sel = 2'd0;
    set_waits(0, 0);
    fill_random_mem();

    begin_reset("sub_z1");
    load_sub_prog(8'h05);
    set_waits(0, 0);
    run_prog("sub_z1", 2000);

    begin_reset("sub_z0");
    load_sub_prog(8'h04);
    run_prog("sub_z0", 2000);

    begin_reset("not");
    load_not_prog();
    run_prog("not", 2000);

    begin_reset("sub_wait");
    load_sub_prog(8'h05);
    set_waits(3, 3);
    run_prog("sub_wait", 2000);

    begin_reset("not_wait");
    load_not_prog();
    run_prog("not_wait", 2000);

    // JZ not taken, LDI R0,FF, JMP FF, INC R0 at FF wraps PC to 00, JZ taken to HALT.
    begin_reset("wrap");
    fill_random_mem();
    mem[0] = 8'hA0; mem[1] = 8'h06;
    mem[2] = 8'h80; mem[3] = 8'hFF;
    mem[4] = 8'hC0; mem[5] = 8'hFF;
    mem[6] = 8'hE0;
    mem[8'hFF] = 8'h60;
    set_waits(0, 0);
    run_prog("wrap", 2000);

    // Abort an LDI while its operand fetch is stalled, then restart cleanly.
    begin_reset("abort");
    fill_random_mem();
    mem[0] = 8'h80; mem[1] = 8'h77;
    set_waits(0, 0);
    wait_arr[1] = 60;
    exp_q.delete();
    exp_q.push_back(16'h0000);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    check("abort_in_opnd_req", imem_req, 1'b1);
    check("abort_in_opnd_addr", imem_addr, 8'h01);
    begin_reset("abort_mid");
    load_not_prog();
    set_waits(0, 2);
    run_prog("after_abort", 2000);

    for (int t = 0; t < 10; t++) begin
      begin_reset("rand");
      load_random_prog();
      set_waits(0, 2);
      run_prog("rand", 3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have the following ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  program-memory fetch request.
- imem_addr  output  8  fetch address (equals PC).
- imem_ack  input  1  memory has valid data this cycle.
- imem_data  input  8  fetched byte, valid when imem_ack=1.
- alu_a  output  8  ALU operand A.
- alu_b  output  8  ALU operand B.
- alu_op  output  3  ALU opcode: 000 NOT, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 INC, 111 DEC.
- alu_result  input  8  combinational ALU result.
- alu_zero  input  1  ALU zero flag.
- halted  output  1  HALT executed.
- dbg_sel  input  2  register-file read select.
- dbg_data  output  8  contents of R[dbg_sel], combinational.
REQ-002 Reset is fixed as: one clock (clk); reset rst_n, asynchronous, active-low.

Function
REQ-003 State: 8-bit PC; 8-bit instruction register IR; register file R0–R3 (8 bits each); Z flag; FSM with states IDLE, FETCH, DECODE, OPND, EXEC, HALT.
REQ-004 Instruction encoding:
- IR[7]=0 is ALU type: op=IR[6:4], rd=IR[3:2], rs=IR[1:0].
- IR[7]=1 is control type, sub=IR[6:5]:
  - 00 LDI: rd=IR[1:0], imm in the next byte.
  - 01 JZ: target address in the next byte.
  - 10 JMP: target address in the next byte.
  - 11 HALT.
REQ-005 imem_req SHALL be 1 exactly in FETCH and OPND, and imem_addr SHALL equal PC at all times.
REQ-006 Handshake:
- imem_req stays high until a cycle with imem_ack=1.
- Data is sampled on that edge.
- PC increments by 1, wrapping 0xFF→0x00, on every accepted byte.
- imem_ack while imem_req=0 SHALL be ignored.
REQ-007 Transitions:
- IDLE→FETCH after one cycle.
- FETCH→DECODE on ack, with IR←imem_data.
- DECODE→EXEC for ALU type.
- DECODE→OPND for LDI, JZ and JMP.
- DECODE→HALT for HALT.
- OPND→FETCH on ack.
- EXEC→FETCH.
- HALT is terminal until reset.
REQ-008 alu_op SHALL equal IR[6:4], alu_a SHALL equal R[IR[3:2]], and alu_b SHALL equal R[IR[1:0]], continuously.
REQ-009 On the EXEC edge the block SHALL perform R[rd]←alu_result and Z←alu_zero; no other state updates Z.
REQ-010 On the OPND ack edge:
- LDI SHALL perform R[rd]←imem_data.
- JMP SHALL perform PC←imem_data.
- JZ SHALL perform PC←imem_data if Z=1, otherwise PC←PC+1.
REQ-011 An ALU instruction SHALL take 3 cycles plus memory wait cycles (FETCH, DECODE, EXEC).
REQ-012 LDI, JZ and JMP SHALL take 3 cycles plus wait cycles.
REQ-013 When rd=rs, the read SHALL use the pre-write value and the write SHALL land at the EXEC edge.
REQ-014 In HALT the block SHALL hold halted=1 and imem_req=0; PC, R and Z SHALL be frozen.
REQ-015 dbg_data SHALL reflect a register write on the cycle after the write edge.

Reset
REQ-016 While rst_n=0, the block SHALL hold:
- state IDLE;
- PC=0x00, IR=0x00, R0–R3=0x00, Z=0;
- imem_req=0, halted=0.
Outputs respond immediately on rst_n=0, independent of clk.
REQ-017 Reset asserted mid-fetch SHALL drop imem_req the same cycle, discard any partial instruction, and restart fetching from 0x00.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Program {0x80,0x05, 0x81,0x05, 0x21}, ack=1 every cycle: LDI R0,5; LDI R1,5; SUB R0,R1 → R0=0x00, Z=1.
- Then {0xA0,0x10} with Z=1 → PC=0x10.
- Repeat with R1=4 → Z=0, R0=0x01, PC=0x07.
- Program {0x80,0xAA, 0x00} (NOT R0,R0) → R0=0x55.
- Insert 3 wait cycles before each ack → imem_req held, imem_addr stable; results identical.
- JMP 0xFF, then INC R0 at address 0xFF → PC wraps to 0x00 after the fetch.
- HALT (0xE0) → halted=1, imem_req=0 indefinitely.
- Reset pulse mid-OPND → all registers 0x00; next fetch from 0x00.
